alu_wb_stage: RTL and testbench

ALU_WB_STAGE -- requirements
Module: alu_wb_stage

---
 rtl/alu_wb_stage.sv | 86 ++++++++
 tb/tb_alu_wb_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: 2-entry in-order writeback FIFO with {Z,N,C,V} status flags.
// Define ALU_WB_FWD_EN to add the combinational forwarding lookup port.
module alu_wb_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_ovf,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wen,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_we,
`ifdef ALU_WB_FWD_EN
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [3:0]        flags
);
  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic [ADDR_W-1:0] addr_q [2];
  logic [ADDR_W-1:0] addr_d [2];
  logic [1:0]        wen_q, wen_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]        flags_q, flags_d;
  logic              push, pop;
  assign in_ready = count_q != 2'd2;
  assign wb_valid = count_q != 2'd0;
  assign wb_data  = data_q[rd_ptr_q];
  assign wb_addr  = addr_q[rd_ptr_q];
  assign wb_we    = wen_q[rd_ptr_q] & wb_valid;
  assign flags    = flags_q;
  assign push     = in_valid & in_ready;
  assign pop      = wb_valid & wb_ready;
  always_comb begin
    data_d   = data_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    if (push) begin
      data_d[wr_ptr_q] = in_result;
      addr_d[wr_ptr_q] = in_rd;
      wen_d[wr_ptr_q]  = in_wen;
    end
    count_d  = count_q + 2'(push) - 2'(pop);
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    flags_d  = push ? {in_result == '0, in_result[DATA_W-1], in_carry, in_ovf} : flags_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '{default: '0};
      addr_q   <= '{default: '0};
      wen_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      flags_q  <= '0;
    end else begin
      data_q   <= data_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      flags_q  <= flags_d;
    end
  end
`ifdef ALU_WB_FWD_EN
  // The newest entry always sits just behind the write pointer; the head is the older one when full.
  logic hit_new, hit_old;
  assign hit_new  = (count_q != 2'd0) & wen_q[~wr_ptr_q] & (addr_q[~wr_ptr_q] == fwd_addr);
  assign hit_old  = (count_q == 2'd2) & wen_q[rd_ptr_q] & (addr_q[rd_ptr_q] == fwd_addr);
  assign fwd_hit  = hit_new | hit_old;
  assign fwd_data = hit_new ? data_q[~wr_ptr_q] : hit_old ? data_q[rd_ptr_q] : '0;
`endif
endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: scoreboard bench for alu_wb_stage; expected entries queued on push, compared on pop.
module tb_alu_wb_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_carry, in_ovf, in_wen;
  logic        wb_valid, wb_ready, wb_we;
  logic [15:0] in_result, wb_data;
  logic [2:0]  in_rd, wb_addr;
  logic [3:0]  flags, exp_flags;
`ifdef ALU_WB_FWD_EN
  logic [2:0]  fwd_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
`endif
  logic [19:0] sb_q [$];
  logic [19:0] exp_e;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_wb_stage #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry), .in_ovf(in_ovf),
    .in_rd(in_rd), .in_wen(in_wen), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_addr(wb_addr), .wb_we(wb_we),
`ifdef ALU_WB_FWD_EN
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .flags(flags)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One clock: score the handshakes about to happen, advance, then check flags.
  task automatic cyc();
    if (wb_valid && wb_ready) begin
      if (sb_q.size() == 0) check("sb_unexpected_pop", 1, 0);
      else begin
        exp_e = sb_q.pop_front();
        check("sb_entry", {12'h0, wb_we, wb_addr, wb_data}, {12'h0, exp_e});
      end
    end
    if (in_valid && in_ready) begin
      sb_q.push_back({in_wen, in_rd, in_result});
      exp_flags = {in_result == 16'h0, in_result[15], in_carry, in_ovf};
    end
    @(posedge clk); #1;
    check("flags", {28'h0, flags}, {28'h0, exp_flags});
  endtask
  task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] rd,
                       input logic w, input logic c, input logic o);
    in_valid = v; in_result = d; in_rd = rd; in_wen = w; in_carry = c; in_ovf = o;
  endtask
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    exp_flags = 4'h0;
  endtask
  initial begin
    rst = 1'b1; wb_ready = 1'b0; exp_flags = 4'h0;
    drive(0, 16'h0, 3'd0, 0, 0, 0);
`ifdef ALU_WB_FWD_EN
    fwd_addr = 3'd0;
`endif
    do_reset();
    @(posedge clk); #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_we", wb_we, 0);
    check("rst_flags", flags, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_addr", wb_addr, 0);
    wb_ready = 1'b1;
    drive(1, 16'h001B, 3'd3, 1, 0, 0);
    cyc();
    in_valid = 1'b0;
    check("lat_wb_valid", wb_valid, 1);
    check("lat_wb_data", wb_data, 16'h001B);
    check("lat_wb_addr", wb_addr, 3);
    check("lat_wb_we", wb_we, 1);
    cyc();
    check("lat_drained", wb_valid, 0);
    wb_ready = 1'b0;
    drive(1, 16'h0000, 3'd1, 1, 0, 0); cyc();
    drive(1, 16'h8000, 3'd2, 1, 0, 0); cyc();
    check("full_in_ready", in_ready, 0);
    check("full_flags", flags, 4'b0100);
    drive(1, 16'h1234, 3'd7, 1, 1, 1); cyc();
    check("refused_in_ready", in_ready, 0);
    check("stall_hold_data", wb_data, 16'h0000);
    check("stall_hold_addr", wb_addr, 1);
    in_valid = 1'b0; wb_ready = 1'b1;
    cyc(); cyc();
    check("order_drained", wb_valid, 0);
    check("order_sb_empty", sb_q.size(), 0);
    wb_ready = 1'b0;
    drive(1, 16'hFFFF, 3'd4, 0, 1, 1); cyc();
    in_valid = 1'b0;
    check("nowen_flags", flags, 4'b0111);
    check("nowen_wb_valid", wb_valid, 1);
    check("nowen_wb_we", wb_we, 0);
    wb_ready = 1'b1; cyc();
    wb_ready = 1'b1;
    drive(1, 16'h0101, 3'd1, 1, 0, 0); cyc();
    drive(1, 16'h0202, 3'd2, 1, 1, 0); cyc();
    check("pushpop_in_ready", in_ready, 1);
    drive(1, 16'h0303, 3'd3, 0, 0, 1); cyc();
    in_valid = 1'b0; cyc(); cyc();
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (i % 17 == 0) in_result = 16'h0;
      wb_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    in_valid = 1'b0; wb_ready = 1'b1;
    cyc(); cyc(); cyc();
    check("rand_sb_empty", sb_q.size(), 0);
    wb_ready = 1'b0;
    drive(1, 16'h0A0A, 3'd6, 1, 0, 0); cyc();
    drive(1, 16'h0B0B, 3'd7, 1, 0, 0); cyc();
    check("prerst_full", in_ready, 0);
    do_reset();
    check("midrst_wb_valid", wb_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_wb_we", wb_we, 0);
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("midrst_no_write", {wb_valid, wb_we}, 0);
    end
`ifdef ALU_WB_FWD_EN
    wb_ready = 1'b0;
    drive(1, 16'h00AA, 3'd5, 1, 0, 0); cyc();
    drive(1, 16'h0055, 3'd5, 1, 0, 0); cyc();
    in_valid = 1'b0;
    fwd_addr = 3'd5; #1;
    check("fwd_hit5", fwd_hit, 1);
    check("fwd_data5", fwd_data, 16'h0055);
    fwd_addr = 3'd2; #1;
    check("fwd_hit2", fwd_hit, 0);
    check("fwd_data2", fwd_data, 16'h0000);
    wb_ready = 1'b1; cyc();
    fwd_addr = 3'd5; #1;
    check("fwd_hit_one", fwd_hit, 1);
    check("fwd_data_one", fwd_data, 16'h0055);
    cyc();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
